// File: rtl/ipv4_rx.sv
// ipv4_rx: IPv4 receive stage sitting behind the MAC RX stage.
// Parses the fixed 20-byte IPv4 header (version/IHL, total length, fragmentation,
// protocol, destination address, header checksum). It forwards the payload, trimmed
// to the total length, and drops failing packets with a one-cycle err_o pulse.
//
// Ports:
//   clk, nreset                  clock, asynchronous active-low reset
//   cancel_i                     abort current packet (qualified by valid_i)
//   valid_i, start_i, data_i     MAC payload beat, start marks IPv4 header word 0
//   len_i                        valid bytes in beat (1 or 2)
//   dst_ip_i                     local IPv4 address (static)
//   valid_o, start_o, last_o     payload beat framing
//   data_o, len_o                payload beat data / byte count
//   hdr_v_o                      pulse: header accepted
//   src_ip_o, pay_len_o          source address / payload length, held until next hdr_v_o
//   err_o                        pulse: packet dropped
module ipv4_rx #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 2,
    parameter logic [7:0]  PROTO  = 8'd17
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cancel_i,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [31:0]       dst_ip_i,
    output logic              valid_o,
    output logic              start_o,
    output logic              last_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              hdr_v_o,
    output logic [31:0]       src_ip_o,
    output logic [15:0]       pay_len_o,
    output logic              err_o
);

    typedef enum logic [1:0] {StIdle, StHead, StData, StDrop} state_t;

    // One's-complement 16-bit add with end-around carry.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [15:0] acc_q, acc_d;
    logic        bad_q, bad_d;
    logic [15:0] tlen_q, tlen_d;
    logic [31:0] src_q, src_d;
    logic [15:0] rem_q, rem_d;
    logic        first_q, first_d;

    logic              valid_d, start_d, last_d, hdr_v_d, err_d;
    logic [DATA_W-1:0] data_d;
    logic [LEN_W-1:0]  len_d;
    logic [31:0]       src_ip_d;
    logic [15:0]       pay_len_d;

    logic [15:0] acc_nxt;
    logic [15:0] len_ext;
    logic        hdr_bad;
    logic        bad_nxt;
    logic        in_pkt;

    assign acc_nxt = csum_add(acc_q, data_i);
    assign len_ext = 16'(len_i);
    // A start or cancel abandons a packet only if one was actually in flight.
    assign in_pkt  = (state_q == StHead) || (state_q == StData);

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        acc_d     = acc_q;
        bad_d     = bad_q;
        tlen_d    = tlen_q;
        src_d     = src_q;
        rem_d     = rem_q;
        first_d   = first_q;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        last_d    = 1'b0;
        hdr_v_d   = 1'b0;
        err_d     = 1'b0;
        data_d    = data_o;
        len_d     = len_o;
        src_ip_d  = src_ip_o;
        pay_len_d = pay_len_o;
        hdr_bad   = 1'b0;
        bad_nxt   = bad_q;

        if (valid_i) begin
            if (cancel_i) begin
                state_d = StIdle;
                wcnt_d  = 4'd0;
                acc_d   = 16'd0;
                err_d   = in_pkt;
            end else if (start_i) begin
                err_d   = in_pkt;
                state_d = StHead;
                wcnt_d  = 4'd1;
                acc_d   = csum_add(16'd0, data_i);
                bad_d   = (data_i[15:12] != 4'd4) || (data_i[11:8] != 4'd5) ||
                          (len_i != LEN_W'(2));
            end else begin
                case (state_q)
                    StHead: begin
                        acc_d  = acc_nxt;
                        wcnt_d = wcnt_q + 4'd1;
                        case (wcnt_q)
                            4'd1: begin
                                tlen_d  = data_i;
                                hdr_bad = data_i < 16'd20;
                            end
                            4'd3: hdr_bad = data_i[13] || (data_i[12:0] != 13'd0);
                            4'd4: hdr_bad = data_i[7:0] != PROTO;
                            4'd6: src_d[31:16] = data_i;
                            4'd7: src_d[15:0]  = data_i;
                            4'd8: hdr_bad = data_i != dst_ip_i[31:16];
                            4'd9: hdr_bad = data_i != dst_ip_i[15:0];
                            default: hdr_bad = 1'b0;
                        endcase
                        bad_nxt = bad_q || hdr_bad || (len_i != LEN_W'(2));
                        bad_d   = bad_nxt;
                        if (wcnt_q == 4'd9) begin
                            if (!bad_nxt && (acc_nxt == 16'hFFFF)) begin
                                hdr_v_d   = 1'b1;
                                src_ip_d  = src_q;
                                pay_len_d = tlen_q - 16'd20;
                                rem_d     = tlen_q - 16'd20;
                                first_d   = 1'b1;
                                state_d   = (tlen_q == 16'd20) ? StDrop : StData;
                            end else begin
                                err_d   = 1'b1;
                                state_d = StDrop;
                            end
                        end
                    end
                    StData: begin
                        valid_d = 1'b1;
                        data_d  = data_i;
                        start_d = first_q;
                        first_d = 1'b0;
                        if (len_ext >= rem_q) begin
                            len_d   = LEN_W'(rem_q);
                            last_d  = 1'b1;
                            rem_d   = 16'd0;
                            state_d = StDrop;
                        end else begin
                            len_d = len_i;
                            rem_d = rem_q - len_ext;
                            // A short beat before the payload is complete means the
                            // MAC stream ended early.
                            if (len_i != LEN_W'(2)) begin
                                err_d   = 1'b1;
                                state_d = StIdle;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= StIdle;
            wcnt_q    <= 4'd0;
            acc_q     <= 16'd0;
            bad_q     <= 1'b0;
            tlen_q    <= 16'd0;
            src_q     <= 32'd0;
            rem_q     <= 16'd0;
            first_q   <= 1'b0;
            valid_o   <= 1'b0;
            start_o   <= 1'b0;
            last_o    <= 1'b0;
            data_o    <= '0;
            len_o     <= '0;
            hdr_v_o   <= 1'b0;
            src_ip_o  <= 32'd0;
            pay_len_o <= 16'd0;
            err_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            acc_q     <= acc_d;
            bad_q     <= bad_d;
            tlen_q    <= tlen_d;
            src_q     <= src_d;
            rem_q     <= rem_d;
            first_q   <= first_d;
            valid_o   <= valid_d;
            start_o   <= start_d;
            last_o    <= last_d;
            data_o    <= data_d;
            len_o     <= len_d;
            hdr_v_o   <= hdr_v_d;
            src_ip_o  <= src_ip_d;
            pay_len_o <= pay_len_d;
            err_o     <= err_d;
        end
    end

endmodule

// File: tb/tb_ipv4_rx.sv
// tb_ipv4_rx: directed self-checking bench for ipv4_rx.
module tb_ipv4_rx;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cancel_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] data_i = 16'd0;
    logic [1:0]  len_i = 2'd0;
    logic [31:0] dst_ip_i = 32'hC0A8_0002;
    logic        valid_o, start_o, last_o, hdr_v_o, err_o;
    logic [15:0] data_o;
    logic [1:0]  len_o;
    logic [31:0] src_ip_o;
    logic [15:0] pay_len_o;

    ipv4_rx #(.DATA_W(16), .LEN_W(2), .PROTO(8'd17)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .cancel_i  (cancel_i),
        .valid_i   (valid_i),
        .start_i   (start_i),
        .data_i    (data_i),
        .len_i     (len_i),
        .dst_ip_i  (dst_ip_i),
        .valid_o   (valid_o),
        .start_o   (start_o),
        .last_o    (last_o),
        .data_o    (data_o),
        .len_o     (len_o),
        .hdr_v_o   (hdr_v_o),
        .src_ip_o  (src_ip_o),
        .pay_len_o (pay_len_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_vo, n_err, n_hdr, n_so, n_lo;
    logic [15:0] q_data[$];
    logic [1:0]  q_len[$];
    logic        q_start[$];
    logic        q_last[$];
    logic [15:0] hdr [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_vo = 0; n_err = 0; n_hdr = 0; n_so = 0; n_lo = 0;
        q_data.delete(); q_len.delete(); q_start.delete(); q_last.delete();
    endtask

    // Drive one beat, then sample the registered response 1 time unit after the edge.
    task automatic beat(input logic s, input logic [15:0] d, input logic [1:0] l,
                        input logic c);
        valid_i = 1'b1; start_i = s; data_i = d; len_i = l; cancel_i = c;
        @(posedge clk);
        #1;
        valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
        if (valid_o) begin
            n_vo++;
            q_data.push_back(data_o); q_len.push_back(len_o);
            q_start.push_back(start_o); q_last.push_back(last_o);
        end
        if (start_o) n_so++;
        if (last_o)  n_lo++;
        if (err_o)   n_err++;
        if (hdr_v_o) n_hdr++;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_good();
        hdr = '{16'h4500, 16'h0024, 16'h0000, 16'h4000, 16'h4011, 16'hB975,
                16'hC0A8, 16'h0001, 16'hC0A8, 16'h0002};
    endtask

    // Header with computed checksum; flip corrupts checksum bit 0.
    task automatic build_hdr(input logic [15:0] w0, input logic [15:0] tl,
                             input logic [15:0] w3, input logic [15:0] w4,
                             input logic [15:0] w9, input logic flip);
        logic [16:0] s;
        logic [15:0] acc;
        hdr = '{w0, tl, 16'h0000, w3, w4, 16'h0000, 16'hC0A8, 16'h0001, 16'hC0A8, w9};
        acc = 16'd0;
        for (int i = 0; i < 10; i++) begin
            s   = {1'b0, acc} + {1'b0, hdr[i]};
            acc = s[15:0] + {15'd0, s[16]};
        end
        hdr[5] = ~acc ^ {15'd0, flip};
    endtask

    task automatic send_hdr(input int n);
        for (int i = 0; i < n; i++) beat(i == 0, hdr[i], 2'd2, 1'b0);
    endtask

    task automatic send_pay(input int n, input int pad);
        for (int i = 0; i < n; i++) beat(1'b0, 16'hA000 + 16'(i), 2'd2, 1'b0);
        for (int i = 0; i < pad; i++) beat(1'b0, 16'h0000, 2'd2, 1'b0);
    endtask

    initial begin
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {25'd0, valid_o, start_o, last_o, hdr_v_o, err_o, len_o}, 32'd0);
        chk("rst_data", {16'd0, data_o}, 32'd0);
        chk("rst_src", src_ip_o, 32'd0);
        chk("rst_paylen", {16'd0, pay_len_o}, 32'd0);
        nreset = 1'b1;
        idle();

        // Good packet, 16 payload bytes, idle gap mid-payload, 2 pad beats.
        clr(); load_good(); send_hdr(10);
        chk("good_hdr_v", {31'd0, hdr_v_o}, 32'd1);
        chk("good_paylen", {16'd0, pay_len_o}, 32'd16);
        chk("good_src", src_ip_o, 32'hC0A8_0001);
        send_pay(4, 0);
        idle();
        chk("gap_valid", {31'd0, valid_o}, 32'd0);
        chk("gap_hold", {16'd0, data_o}, 32'h0000_A003);
        for (int i = 4; i < 8; i++) beat(1'b0, 16'hA000 + 16'(i), 2'd2, 1'b0);
        chk("good_last_len", {30'd0, len_o}, 32'd2);
        send_pay(0, 2);
        chk("good_nvo", n_vo, 8);
        chk("good_start", {31'd0, q_start[0]}, 32'd1);
        chk("good_nstart", n_so, 1);
        chk("good_last", {31'd0, q_last[7]}, 32'd1);
        chk("good_nlast", n_lo, 1);
        chk("good_data3", {16'd0, q_data[3]}, 32'h0000_A003);
        chk("good_nerr", n_err, 0);
        chk("good_nhdr", n_hdr, 1);

        // Odd payload: 3 bytes.
        clr(); build_hdr(16'h4500, 16'h0017, 16'h4000, 16'h4011, 16'h0002, 1'b0);
        send_hdr(10); send_pay(2, 2);
        chk("odd_nvo", n_vo, 2);
        chk("odd_len0", {30'd0, q_len[0]}, 32'd2);
        chk("odd_last0", {31'd0, q_last[0]}, 32'd0);
        chk("odd_len1", {30'd0, q_len[1]}, 32'd1);
        chk("odd_last1", {31'd0, q_last[1]}, 32'd1);
        chk("odd_nerr", n_err, 0);

        // Header check failures: each pulses err_o right after w9, no payload.
        for (int k = 0; k < 5; k++) begin
            clr();
            case (k)
                0: build_hdr(16'h4500, 16'h0024, 16'h4000, 16'h4011, 16'h0002, 1'b1);
                1: build_hdr(16'h4500, 16'h0024, 16'h4000, 16'h4006, 16'h0002, 1'b0);
                2: build_hdr(16'h4500, 16'h0024, 16'h4000, 16'h4011, 16'h0003, 1'b0);
                3: build_hdr(16'h4600, 16'h0024, 16'h4000, 16'h4011, 16'h0002, 1'b0);
                default: build_hdr(16'h4500, 16'h0024, 16'h2000, 16'h4011, 16'h0002, 1'b0);
            endcase
            send_hdr(9);
            chk($sformatf("bad%0d_noerr_early", k), n_err, 0);
            beat(1'b0, hdr[9], 2'd2, 1'b0);
            chk($sformatf("bad%0d_err", k), {31'd0, err_o}, 32'd1);
            send_pay(8, 2);
            chk($sformatf("bad%0d_nerr", k), n_err, 1);
            chk($sformatf("bad%0d_nvo", k), n_vo, 0);
            chk($sformatf("bad%0d_nhdr", k), n_hdr, 0);
            clr(); load_good(); send_hdr(10); send_pay(8, 0);
            chk($sformatf("bad%0d_recover", k), n_hdr * 16 + n_vo, 24);
        end

        // Cancel on payload beat 3.
        clr(); load_good(); send_hdr(10); send_pay(2, 0);
        beat(1'b0, 16'hA002, 2'd2, 1'b1);
        chk("cancel_valid", {31'd0, valid_o}, 32'd0);
        chk("cancel_err", {31'd0, err_o}, 32'd1);
        for (int i = 3; i < 8; i++) beat(1'b0, 16'hA000 + 16'(i), 2'd2, 1'b0);
        chk("cancel_nvo", n_vo, 2);
        clr(); load_good(); send_hdr(10); send_pay(8, 0);
        chk("cancel_recover", n_hdr * 16 + n_vo, 24);
        chk("cancel_rec_err", n_err, 0);

        // Restart at header w5.
        clr(); load_good(); send_hdr(5);
        beat(1'b1, hdr[0], 2'd2, 1'b0);
        chk("restart_err", {31'd0, err_o}, 32'd1);
        for (int i = 1; i < 10; i++) beat(1'b0, hdr[i], 2'd2, 1'b0);
        chk("restart_hdr_v", {31'd0, hdr_v_o}, 32'd1);
        send_pay(8, 0);
        chk("restart_nvo", n_vo, 8);
        chk("restart_nerr", n_err, 1);

        // total_len = 20: header accepted, no payload.
        clr(); build_hdr(16'h4500, 16'h0014, 16'h4000, 16'h4011, 16'h0002, 1'b0);
        send_hdr(10);
        chk("empty_hdr_v", {31'd0, hdr_v_o}, 32'd1);
        chk("empty_paylen", {16'd0, pay_len_o}, 32'd0);
        send_pay(2, 0);
        chk("empty_nvo", n_vo, 0);
        chk("empty_nerr", n_err, 0);

        // MAC stream ends early with a 1-byte beat inside the payload.
        clr(); load_good(); send_hdr(10); send_pay(3, 0);
        beat(1'b0, 16'hA300, 2'd1, 1'b0);
        chk("short_valid", {31'd0, valid_o}, 32'd1);
        chk("short_len", {30'd0, len_o}, 32'd1);
        chk("short_last", {31'd0, last_o}, 32'd0);
        chk("short_err", {31'd0, err_o}, 32'd1);
        send_pay(2, 0);
        chk("short_nvo", n_vo, 4);

        // Async reset in the middle of DATA.
        clr(); load_good(); send_hdr(10); send_pay(2, 0);
        chk("prerst_valid", {31'd0, valid_o}, 32'd1);
        #2 nreset = 1'b0;
        #1;
        chk("arst_ctrl", {25'd0, valid_o, start_o, last_o, hdr_v_o, err_o, len_o}, 32'd0);
        chk("arst_data", {16'd0, data_o}, 32'd0);
        chk("arst_src", src_ip_o, 32'd0);
        chk("arst_paylen", {16'd0, pay_len_o}, 32'd0);
        idle();
        nreset = 1'b1;
        clr(); send_pay(2, 0);
        chk("arst_idle_nvo", n_vo, 0);
        clr(); load_good(); send_hdr(10); send_pay(8, 0);
        chk("arst_recover", n_hdr * 16 + n_vo, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
